// File: rtl/uart_pkg.sv
// Shared state encoding, status bit positions and default register addresses
// for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVR   = 2;
  localparam int STAT_EMPTY = 3;

  localparam logic [31:0] DEF_TX_ADDR   = 32'h1001_0024;
  localparam logic [31:0] DEF_STAT_ADDR = 32'h1001_0028;

  function automatic logic [31:0] pack_status(input logic busy, input logic full,
                                              input logic ovr, input logic empty);
    logic [31:0] s;
    s             = '0;
    s[STAT_BUSY]  = busy;
    s[STAT_FULL]  = full;
    s[STAT_OVR]   = ovr;
    s[STAT_EMPTY] = empty;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular synchronous FIFO used as the transmit buffer when the design is
// built with UART_TX_FIFO_EN; a pop frees its slot for a push in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the store path with a pollable status
// register. Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry buffer instead of a holding register.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [31:0] TX_ADDR      = DEF_TX_ADDR,
  parameter logic [31:0] STAT_ADDR    = DEF_STAT_ADDR,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_enable_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Write_Data_i,
  output logic [31:0] Read_Data_o,
  output logic        hit_o,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  if (CLKS_PER_BIT < 2 || FIFO_DEPTH < 1) begin : g_bad_params
    $error("uart_tx_mmio: CLKS_PER_BIT must be >= 2 and FIFO_DEPTH >= 1");
  end

  uart_state_t       state;
  uart_state_t       state_n;
  logic [BAUD_W-1:0] baud;
  logic [BAUD_W-1:0] baud_n;
  logic [2:0]        bit_idx;
  logic [2:0]        bit_idx_n;
  logic [7:0]        shift;
  logic [7:0]        shift_n;
  logic              bit_done;
  logic              tx_next;

  logic              tx_sel;
  logic              stat_sel;
  logic              wr_tx;
  logic              wr_stat;
  logic              push;
  logic              pop;
  logic              drop;
  logic              overrun;
  logic              buf_full;
  logic              buf_empty;
  logic [7:0]        buf_data;
  logic              unused_wdata;

  assign tx_sel       = (Address_i == TX_ADDR);
  assign stat_sel     = (Address_i == STAT_ADDR);
  assign hit_o        = tx_sel || stat_sel;
  assign wr_tx        = write_enable_i && tx_sel;
  assign wr_stat      = write_enable_i && stat_sel;
  assign unused_wdata = ^Write_Data_i[31:8];

  // A dequeue on this edge frees a slot, so a store landing on a full buffer still fits.
  assign push = wr_tx && (!buf_full || pop);
  assign drop = wr_tx && buf_full && !pop;

`ifdef UART_TX_FIFO_EN
  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(Write_Data_i[7:0]),
    .pop      (pop),
    .pop_data (buf_data),
    .full     (buf_full),
    .empty    (buf_empty)
  );
`else
  logic       hold_valid;
  logic [7:0] hold_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (push) begin
      hold_valid <= 1'b1;
      hold_data  <= Write_Data_i[7:0];
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign buf_full  = hold_valid;
  assign buf_empty = !hold_valid;
  assign buf_data  = hold_data;
`endif

  assign bit_done = (baud == BAUD_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!buf_empty) begin
          pop     = 1'b1;
          shift_n = buf_data;
          baud_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (bit_done) begin
          baud_n    = '0;
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_n    = '0;
          shift_n   = {1'b0, shift[7:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_n = '0;
          if (!buf_empty) begin
            pop     = 1'b1;
            shift_n = buf_data;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The line and busy flag are registered from the current state, so they trail it by one edge.
  assign tx_next = (state == START) ? 1'b0 : (state == DATA) ? shift[0] : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_o    <= 1'b1;
      busy_o  <= 1'b0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx_o    <= tx_next;
      busy_o  <= (state != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (wr_stat && Write_Data_i[STAT_OVR]) begin
      overrun <= 1'b0;
    end
  end

  assign Read_Data_o = stat_sel ? pack_status(busy_o, buf_full, overrun, buf_empty) : '0;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: directed scenarios plus random stores,
// all compared against a frame-level reference model of the transmitter.
module tb_uart_tx_mmio;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [31:0] TXA = 32'h1001_0024;
  localparam logic [31:0] STA = 32'h1001_0028;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_enable_i;
  logic [31:0] Address_i;
  logic [31:0] Write_Data_i;
  logic [31:0] Read_Data_o;
  logic        hit_o;
  logic        tx_o;
  logic        busy_o;

  uart_tx_mmio #(
    .CLKS_PER_BIT(CPB),
    .TX_ADDR     (TXA),
    .STAT_ADDR   (STA),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .write_enable_i(write_enable_i),
    .Address_i     (Address_i),
    .Write_Data_i  (Write_Data_i),
    .Read_Data_o   (Read_Data_o),
    .hit_o         (hit_o),
    .tx_o          (tx_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pending bytes, and the frame in flight as a byte plus a
  // cycle position inside its 10-bit-period window.
  logic [7:0] mq[$];
  bit         m_active;
  int         m_pos;
  logic [7:0] m_byte;
  bit         m_ovr;
  bit         m_tx;
  bit         m_busy;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit line_level(input logic [7:0] b, input int pos);
    int slot;
    slot = pos / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_status();
    int full;
    int empty;
    full  = (mq.size() == DEPTH) ? 1 : 0;
    empty = (mq.size() == 0) ? 1 : 0;
    return 32'(int'(m_busy) + 2 * full + 4 * int'(m_ovr) + 8 * empty);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_active = 1'b0;
    m_pos    = 0;
    m_byte   = '0;
    m_ovr    = 1'b0;
    m_tx     = 1'b1;
    m_busy   = 1'b0;
  endtask

  task automatic model_edge(input bit we, input logic [31:0] addr, input logic [31:0] data);
    bit do_pop;
    m_tx   = m_active ? line_level(m_byte, m_pos) : 1'b1;
    m_busy = m_active;
    do_pop = (mq.size() > 0) && (!m_active || m_pos == FRAME - 1);
    if (m_active) begin
      if (m_pos == FRAME - 1) m_active = 1'b0;
      else m_pos++;
    end
    if (do_pop) begin
      m_byte   = mq.pop_front();
      m_active = 1'b1;
      m_pos    = 0;
    end
    if (we && addr == TXA) begin
      if (mq.size() < DEPTH) mq.push_back(data[7:0]);
      else m_ovr = 1'b1;
    end else if (we && addr == STA && data[2]) begin
      m_ovr = 1'b0;
    end
  endtask

  // One clock of stimulus: combinational checks before the edge, registered checks after it.
  task automatic applyStimulus(input bit rst, input bit we, input logic [31:0] addr,
                               input logic [31:0] data);
    reset          = rst;
    write_enable_i = we;
    Address_i      = addr;
    Write_Data_i   = data;
    #2;
    if (!rst) begin
      checkOutput("hit", 32'(hit_o), 32'((addr == TXA) || (addr == STA)));
      checkOutput("rdata", Read_Data_o, (addr == STA) ? model_status() : 32'h0);
    end
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(we, addr, data);
    #1;
    checkOutput("tx", 32'(tx_o), 32'(m_tx));
    checkOutput("busy", 32'(busy_o), 32'(m_busy));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, STA, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    write_enable_i = 1'b0;
    Address_i      = STA;
    Write_Data_i   = '0;
    model_reset();
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, STA, 32'h0);
    reset = 1'b0;
    #1;
    checkOutput("rst_status", Read_Data_o, 32'h8);
    checkOutput("rst_tx", 32'(tx_o), 32'h1);
    checkOutput("rst_busy", 32'(busy_o), 32'h0);

    // Single frame; busy must drop exactly 42 edges after the accepting edge.
    applyStimulus(1'b0, 1'b1, TXA, 32'h0000_00A5);
    for (int i = 1; i <= 45; i++) begin
      applyStimulus(1'b0, 1'b0, STA, 32'h0);
      if (i == 1) checkOutput("a5_not_started", 32'(tx_o), 32'h1);
      if (i == 2) checkOutput("a5_start_bit", 32'(tx_o), 32'h0);
      if (i == 41) checkOutput("a5_busy_n41", 32'(busy_o), 32'h1);
      if (i == 42) checkOutput("a5_busy_n42", 32'(busy_o), 32'h0);
    end

    // Back-to-back stores, one more than the buffer can absorb, to force an overrun.
    applyStimulus(1'b0, 1'b1, TXA, 32'h0000_0055);
    applyStimulus(1'b0, 1'b1, TXA, 32'h0000_000F);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, TXA, 32'($urandom_range(0, 255)));
    Address_i      = STA;
    write_enable_i = 1'b0;
    #1;
    checkOutput("b2b_status", Read_Data_o, 32'h7);

    idle(10);
    applyStimulus(1'b0, 1'b1, STA, 32'h0000_0004);
    Address_i      = STA;
    write_enable_i = 1'b0;
    #1;
    checkOutput("ovr_clear", 32'(Read_Data_o[2]), 32'h0);
    idle(FRAME * (DEPTH + 1) + 10);

    // Reset during data bit 3 aborts the frame and leaves the line idle.
    applyStimulus(1'b0, 1'b1, TXA, 32'h0000_00C3);
    idle(18);
    applyStimulus(1'b1, 1'b0, STA, 32'h0);
    checkOutput("midrst_tx", 32'(tx_o), 32'h1);
    checkOutput("midrst_busy", 32'(busy_o), 32'h0);
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b0, 1'b0, STA, 32'h0);
      checkOutput("midrst_quiet", 32'(tx_o), 32'h1);
    end

    // Random traffic: data stores, status writes, stray addresses and rare resets.
    for (int i = 0; i < 2000; i++) begin
      int          r;
      logic [31:0] a;
      logic [31:0] d;
      r = int'($urandom_range(0, 999));
      d = $urandom;
      if (r < 3) begin
        applyStimulus(1'b1, 1'b0, STA, 32'h0);
      end else if (r < 110) begin
        applyStimulus(1'b0, 1'b1, TXA, d);
      end else if (r < 135) begin
        applyStimulus(1'b0, 1'b1, STA, d);
      end else if (r < 185) begin
        a = $urandom;
        applyStimulus(1'b0, int'($urandom_range(0, 1)) == 1, a, d);
      end else if (r < 200) begin
        applyStimulus(1'b0, 1'b0, TXA, d);
      end else begin
        applyStimulus(1'b0, 1'b0, STA, 32'h0);
      end
    end
    idle(FRAME * (DEPTH + 1) + 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
